// File: rtl/mux_tree_pipe.sv
// Pipelined N-to-1 mux: binary tree of 2-to-1 stages, one register level per tree level.
// Latency: LEVELS = log2(NUM_INPUTS) cycles, 1 word/cycle sustained.
// Backpressure: per-stage valid/ready with bubble collapsing; ready path is combinational, no skid.
//
// Ports:
//   clk_in, rst_n_in          - clock, synchronous active-low reset
//   data_in, sel_in, valid_in - input word (channel k at [k*DATA_WIDTH +: DATA_WIDTH]), select, valid
//   ready_out                 - block accepts the input word this cycle
//   y_out, valid_out          - selected channel data and its valid
//   ready_in                  - downstream accepts y_out
module mux_tree_pipe #(
    parameter int NUM_INPUTS = 8,
    parameter int DATA_WIDTH = 8,
    parameter int SEL_WIDTH  = $clog2(NUM_INPUTS),
    parameter int LEVELS     = SEL_WIDTH
) (
    input  logic                             clk_in,
    input  logic                             rst_n_in,
    input  logic [NUM_INPUTS*DATA_WIDTH-1:0] data_in,
    input  logic [SEL_WIDTH-1:0]             sel_in,
    input  logic                             valid_in,
    output logic                             ready_out,
    output logic [DATA_WIDTH-1:0]            y_out,
    output logic                             valid_out,
    input  logic                             ready_in
);

    if (NUM_INPUTS < 2 || (NUM_INPUTS & (NUM_INPUTS - 1)) != 0 ||
        SEL_WIDTH != $clog2(NUM_INPUTS) || LEVELS != SEL_WIDTH) begin : gen_param_err
        $error("mux_tree_pipe: NUM_INPUTS must be a power of 2 >= 2; SEL_WIDTH/LEVELS are derived");
    end

    logic [LEVELS-1:0] vld;
    logic [LEVELS-1:0] adv;

    // A stage may advance if any stage from it down to the output is empty,
    // or the consumer takes the output word. This is the unrolled form of
    // adv[L] = !v[L] || adv[L+1], written without a self-referencing vector.
    always_comb begin
        adv = '0;
        for (int l = 0; l < LEVELS; l++) begin
            adv[l] = ready_in;
            for (int k = l; k < LEVELS; k++) begin
                if (!vld[k]) begin
                    adv[l] = 1'b1;
                end
            end
        end
    end

    for (genvar l = 0; l < LEVELS; l++) begin : gen_lvl
        localparam int IN_WORDS  = NUM_INPUTS >> l;
        localparam int OUT_WORDS = NUM_INPUTS >> (l + 1);
        localparam int UP_SEL_W  = SEL_WIDTH - l;

        logic [IN_WORDS*DATA_WIDTH-1:0]  up_dat;
        logic [UP_SEL_W-1:0]             up_sel;
        logic                            up_vld;
        logic [OUT_WORDS*DATA_WIDTH-1:0] mux_dat;
        logic [OUT_WORDS*DATA_WIDTH-1:0] dat_q;
        logic                            vld_q;

        if (l == 0) begin : gen_src
            assign up_dat = data_in;
            assign up_sel = sel_in;
            assign up_vld = valid_in;
        end else begin : gen_src
            assign up_dat = gen_lvl[l-1].dat_q;
            assign up_sel = gen_lvl[l-1].gen_sel.sel_q;
            assign up_vld = gen_lvl[l-1].vld_q;
        end

        // Bit 0 of the select reaching this level picks odd/even of each pair.
        always_comb begin
            mux_dat = '0;
            for (int j = 0; j < OUT_WORDS; j++) begin
                mux_dat[j*DATA_WIDTH +: DATA_WIDTH] = up_sel[0] ?
                    up_dat[(2*j+1)*DATA_WIDTH +: DATA_WIDTH] :
                    up_dat[(2*j)*DATA_WIDTH +: DATA_WIDTH];
            end
        end

        // Data holds when an empty slot moves in, so an idle output keeps its last value.
        always_ff @(posedge clk_in) begin
            if (!rst_n_in) begin
                vld_q <= 1'b0;
                dat_q <= '0;
            end else if (adv[l]) begin
                vld_q <= up_vld;
                if (up_vld) begin
                    dat_q <= mux_dat;
                end
            end
        end

        assign vld[l] = vld_q;

        if (l < LEVELS - 1) begin : gen_sel
            // Only the select bits still needed by later levels travel on.
            logic [UP_SEL_W-2:0] sel_q;
            always_ff @(posedge clk_in) begin
                if (!rst_n_in) begin
                    sel_q <= '0;
                end else if (adv[l] && up_vld) begin
                    sel_q <= up_sel[UP_SEL_W-1:1];
                end
            end
        end else begin : gen_out
            assign y_out = dat_q;
        end
    end

    assign valid_out = vld[LEVELS-1];
    assign ready_out = adv[0];

endmodule

// File: tb/tb_mux_tree_pipe.sv
module tb_mux_tree_pipe;

    localparam int N   = 8;
    localparam int DW  = 8;
    localparam int LAT = 3;

    typedef struct {
        logic [15:0] dat;
        int          acc;
        bit          chk_lat;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic            rst_n;
    logic [N*DW-1:0] data_in;
    logic [2:0]      sel_in;
    logic            valid_in;
    logic            ready_out;
    logic [DW-1:0]   y_out;
    logic            valid_out;
    logic            ready_in;

    logic [31:0] b_data_in;
    logic        b_sel_in;
    logic        b_valid_in;
    logic        b_ready_out;
    logic [15:0] b_y_out;
    logic        b_valid_out;
    logic        b_ready_in;

    mux_tree_pipe #(.NUM_INPUTS(N), .DATA_WIDTH(DW)) dut (
        .clk_in   (clk),
        .rst_n_in (rst_n),
        .data_in  (data_in),
        .sel_in   (sel_in),
        .valid_in (valid_in),
        .ready_out(ready_out),
        .y_out    (y_out),
        .valid_out(valid_out),
        .ready_in (ready_in)
    );

    mux_tree_pipe #(.NUM_INPUTS(2), .DATA_WIDTH(16)) dut_b (
        .clk_in   (clk),
        .rst_n_in (rst_n),
        .data_in  (b_data_in),
        .sel_in   (b_sel_in),
        .valid_in (b_valid_in),
        .ready_out(b_ready_out),
        .y_out    (b_y_out),
        .valid_out(b_valid_out),
        .ready_in (b_ready_in)
    );

    int   n_cmp = 0;
    int   n_bad = 0;
    int   cyc = 0;
    int   acc_cnt = 0;
    int   rdy_mode = 1;   // 0: hold low, 1: hold high, 2: random
    exp_t q[$];
    exp_t bq[$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Consumer ready, updated just after each rising edge.
    initial begin
        ready_in = 1'b1;
        forever begin
            @(posedge clk);
            #2;
            case (rdy_mode)
                0:       ready_in = 1'b0;
                1:       ready_in = 1'b1;
                default: ready_in = 1'($urandom_range(0, 1));
            endcase
        end
    end

    task automatic set_pattern(input logic [7:0] base, input logic [7:0] step);
        for (int k = 0; k < N; k++) data_in[k*DW +: DW] = base + 8'(k) * step;
    endtask

    // Called just after a rising edge; returns just after the edge that took the word.
    task automatic send(input logic [2:0] s, input logic [7:0] exp, input bit chk_lat);
        exp_t e;
        sel_in   = s;
        valid_in = 1'b1;
        for (int t = 0; t < 64; t++) begin
            @(negedge clk);
            if (ready_out) begin
                e.dat = 16'(exp); e.acc = cyc; e.chk_lat = chk_lat;
                q.push_back(e);
                acc_cnt++;
                @(posedge clk); #1;
                valid_in = 1'b0;
                return;
            end
            @(posedge clk); #1;
        end
        valid_in = 1'b0;
        check("accept_timeout", 32'd0, 32'd1);
    endtask

    task automatic send_b(input logic s, input logic [15:0] exp);
        exp_t e;
        b_sel_in   = s;
        b_valid_in = 1'b1;
        for (int t = 0; t < 64; t++) begin
            @(negedge clk);
            if (b_ready_out) begin
                e.dat = exp; e.acc = cyc; e.chk_lat = 1'b1;
                bq.push_back(e);
                @(posedge clk); #1;
                b_valid_in = 1'b0;
                return;
            end
            @(posedge clk); #1;
        end
        b_valid_in = 1'b0;
        check("b_accept_timeout", 32'd0, 32'd1);
    endtask

    task automatic idle(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic drain();
        for (int t = 0; t < 200 && (q.size() != 0 || bq.size() != 0); t++) begin
            @(posedge clk); #1;
        end
        check("drain_q", 32'(q.size()), 32'd0);
        check("drain_bq", 32'(bq.size()), 32'd0);
    endtask

    // Monitor for the 8-input instance: pops on each output transfer and
    // checks that a stalled output stays put.
    logic          stall;
    logic [DW-1:0] prev_y;
    initial begin
        exp_t e;
        stall = 1'b0;
        prev_y = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                stall = 1'b0;
            end else begin
                if (stall) begin
                    check("stall_valid", 32'(valid_out), 32'd1);
                    check("stall_y", 32'(y_out), 32'(prev_y));
                end
                if (valid_out && ready_in) begin
                    if (q.size() == 0) begin
                        check("spurious_out", 32'(y_out), 32'hDEAD);
                    end else begin
                        e = q.pop_front();
                        check("y_out", 32'(y_out), 32'(e.dat));
                        if (e.chk_lat) check("latency", 32'(cyc - e.acc), 32'(LAT));
                    end
                end
                stall  = valid_out && !ready_in;
                prev_y = y_out;
            end
        end
    end

    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_n && b_valid_out && b_ready_in) begin
                if (bq.size() == 0) begin
                    check("b_spurious_out", 32'(b_y_out), 32'hDEAD);
                end else begin
                    e = bq.pop_front();
                    check("b_y_out", 32'(b_y_out), 32'(e.dat));
                    check("b_latency", 32'(cyc - e.acc), 32'd1);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    logic [7:0] sweep_exp [8] = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h14, 8'h15, 8'h16, 8'h17};
    logic [2:0] bp_sel    [4] = '{3'd5, 3'd2, 3'd7, 3'd1};
    logic [7:0] bp_exp    [4] = '{8'h15, 8'h12, 8'h17, 8'h11};

    initial begin
        int a0;
        rst_n      = 1'b0;
        valid_in   = 1'b1;
        sel_in     = 3'd3;
        set_pattern(8'h10, 8'h01);
        b_data_in  = {16'h5555, 16'hAAAA};
        b_sel_in   = 1'b1;
        b_valid_in = 1'b1;
        b_ready_in = 1'b1;

        // Reset held for two edges with valid_in asserted.
        @(posedge clk); @(posedge clk);
        @(negedge clk);
        check("rst_valid_out", 32'(valid_out), 32'd0);
        check("rst_y_out", 32'(y_out), 32'h0);
        check("rst_b_valid_out", 32'(b_valid_out), 32'd0);
        check("rst_b_y_out", 32'(b_y_out), 32'h0);
        @(posedge clk); #1;
        rst_n      = 1'b1;
        valid_in   = 1'b0;
        b_valid_in = 1'b0;

        // Full sweep, back to back, no stalls.
        for (int s = 0; s < 8; s++) send(3'(s), sweep_exp[s], 1'b1);
        drain();

        // Backpressure: three words absorbed, fourth held off.
        rdy_mode = 0;
        idle(1);
        a0 = acc_cnt;
        fork
            begin
                for (int i = 0; i < 4; i++) send(bp_sel[i], bp_exp[i], 1'b0);
            end
        join_none
        idle(8);
        @(negedge clk);
        check("bp_accepts", 32'(acc_cnt - a0), 32'd3);
        check("bp_ready_out", 32'(ready_out), 32'd0);
        check("bp_valid_out", 32'(valid_out), 32'd1);
        check("bp_y_out", 32'(y_out), 32'h15);
        @(posedge clk); #1;
        rdy_mode = 1;
        @(negedge clk);
        check("full_shift_accept", 32'(ready_out), 32'd1);
        wait fork;
        drain();

        // Bubbles in the input stream with a random consumer.
        set_pattern(8'hA0, 8'h03);
        rdy_mode = 2;
        send(3'd0, 8'hA0, 1'b0);
        idle(1);
        send(3'd3, 8'hA9, 1'b0);
        idle(1);
        send(3'd6, 8'hB2, 1'b0);
        drain();
        rdy_mode = 1;

        // Reset with three words in flight and the consumer stalled.
        set_pattern(8'h10, 8'h01);
        rdy_mode = 0;
        idle(1);
        send(3'd1, 8'h11, 1'b0);
        send(3'd2, 8'h12, 1'b0);
        send(3'd3, 8'h13, 1'b0);
        idle(1);
        @(negedge clk);
        check("pre_rst_valid_out", 32'(valid_out), 32'd1);
        @(posedge clk); #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        q.delete();
        @(negedge clk);
        check("midrst_valid_out", 32'(valid_out), 32'd0);
        check("midrst_y_out", 32'(y_out), 32'h0);
        @(posedge clk); #1;
        rdy_mode = 1;
        send(3'd4, 8'h14, 1'b1);
        drain();

        // Two-input, 16-bit instance: single stage, latency 1.
        send_b(1'b1, 16'h5555);
        send_b(1'b0, 16'hAAAA);
        drain();

        idle(3);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
